// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage in front of writeback_stage.
//
// Issues loads/stores to data memory over a req/ack bus. While a transaction is
// outstanding it stalls upstream. It aligns and extends load data, then
// registers the MEM/WB payload.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   MEM_*_i             : instruction currently in MEM (held by upstream while stalled)
//   MEM_stall_o         : upstream must hold its MEM inputs (combinational)
//   dmem_req_o/we_o     : bus request / write strobe (registered)
//   dmem_addr_o/be_o    : word address and byte enables (registered)
//   dmem_wdata_o        : lane-replicated store data (registered)
//   dmem_ack_i/rdata_i  : transaction complete / read word
//   WB_*_o              : registered MEM/WB payload, WB_exc_o flags a bad access
//
// wb_sel_e encoding: 0 WB_NONE, 1 WB_ALU, 2 WB_MEM, 3 WB_PC4.
module memory_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_valid_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  input  logic [4:0]            MEM_rd_addr_i,
  input  logic                  MEM_RegWrite_i,
  input  logic [1:0]            MEM_WBSel_i,
  output logic                  MEM_stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  WB_valid_o,
  output logic                  WB_RegWrite_o,
  output logic [4:0]            WB_rd_addr_o,
  output logic [1:0]            WB_WBSel_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_rd_data_o,
  output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
  output logic                  WB_exc_o
);

  localparam logic [1:0] WB_NONE = 2'd0;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  // Bus-side latched transaction
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;

  // Latched payload of the outstanding op; its ALU result is {addr_q[31:2], off_q}
  logic [4:0]            lat_rd_q, lat_rd_d;
  logic                  lat_regwrite_q, lat_regwrite_d;
  logic [1:0]            lat_wbsel_q, lat_wbsel_d;
  logic [DATA_WIDTH-1:0] lat_pc4_q, lat_pc4_d;

  // MEM/WB registers
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_regwrite_q, wb_regwrite_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [1:0]            wb_wbsel_q, wb_wbsel_d;
  logic [DATA_WIDTH-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_WIDTH-1:0] wb_rd_data_q, wb_rd_data_d;
  logic [DATA_WIDTH-1:0] wb_pc4_q, wb_pc4_d;
  logic                  wb_exc_q, wb_exc_d;

  logic                  stall;

  // ---------------------------------------------------------------------------
  // Access decode for the incoming instruction
  // ---------------------------------------------------------------------------
  logic                  mem_op;
  logic                  f3_ok;
  logic                  aligned;
  logic                  legal;
  logic [1:0]            in_off;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;

  assign mem_op = MEM_valid_i & (MEM_MemRead_i | MEM_MemWrite_i);
  assign in_off = MEM_alu_result_i[1:0];

  always_comb begin
    f3_ok = 1'b0;
    if (MEM_MemWrite_i) begin
      f3_ok = (MEM_funct3_i == 3'b000) || (MEM_funct3_i == 3'b001) ||
              (MEM_funct3_i == 3'b010);
    end else begin
      f3_ok = (MEM_funct3_i == 3'b000) || (MEM_funct3_i == 3'b001) ||
              (MEM_funct3_i == 3'b010) || (MEM_funct3_i == 3'b100) ||
              (MEM_funct3_i == 3'b101);
    end
  end

  always_comb begin
    aligned = 1'b1;
    unique case (MEM_funct3_i[1:0])
      2'b01:   aligned = (in_off[0] == 1'b0);
      2'b10:   aligned = (in_off == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign legal = f3_ok & aligned;

  // Store lanes; loads request the whole word and drive no data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = '0;
    if (MEM_MemWrite_i) begin
      unique case (MEM_funct3_i[1:0])
        2'b00: begin
          st_be    = 4'b0001 << in_off;
          st_wdata = {4{MEM_rs2_data_i[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << in_off;
          st_wdata = {2{MEM_rs2_data_i[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = MEM_rs2_data_i;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the acked word
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_data;

  assign shifted = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b101:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;  // LW: off_q is 0
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    lat_rd_d       = lat_rd_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_wbsel_d    = lat_wbsel_q;
    lat_pc4_d      = lat_pc4_q;
    // Bubble unless something retires; other WB fields hold
    wb_valid_d     = 1'b0;
    wb_regwrite_d  = 1'b0;
    wb_exc_d       = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_wbsel_d     = wb_wbsel_q;
    wb_alu_d       = wb_alu_q;
    wb_rd_data_d   = wb_rd_data_q;
    wb_pc4_d       = wb_pc4_q;

    unique case (state_q)
      StIdle: begin
        if (mem_op && legal) begin
          stall          = 1'b1;
          state_d        = StBusy;
          req_d          = 1'b1;
          we_d           = MEM_MemWrite_i;
          addr_d         = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
          be_d           = st_be;
          wdata_d        = st_wdata;
          funct3_d       = MEM_funct3_i;
          off_d          = in_off;
          lat_rd_d       = MEM_rd_addr_i;
          lat_regwrite_d = MEM_RegWrite_i;
          lat_wbsel_d    = MEM_WBSel_i;
          lat_pc4_d      = MEM_pc_plus4_i;
        end else begin
          // Non-memory op, bubble, or a bad access retiring as an exception
          wb_valid_d    = MEM_valid_i;
          wb_regwrite_d = MEM_valid_i & MEM_RegWrite_i & ~mem_op;
          wb_exc_d      = mem_op;
          wb_rd_d       = MEM_rd_addr_i;
          wb_wbsel_d    = MEM_WBSel_i;
          wb_alu_d      = MEM_alu_result_i;
          wb_rd_data_d  = '0;
          wb_pc4_d      = MEM_pc_plus4_i;
        end
      end
      StBusy: begin
        stall = ~dmem_ack_i;
        if (dmem_ack_i) begin
          state_d       = StIdle;
          req_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = lat_regwrite_q;
          wb_rd_d       = lat_rd_q;
          wb_wbsel_d    = lat_wbsel_q;
          wb_alu_d      = {addr_q[DATA_WIDTH-1:2], off_q};
          wb_rd_data_d  = we_q ? '0 : ld_data;
          wb_pc4_d      = lat_pc4_q;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      funct3_q       <= '0;
      off_q          <= '0;
      lat_rd_q       <= '0;
      lat_regwrite_q <= 1'b0;
      lat_wbsel_q    <= WB_NONE;
      lat_pc4_q      <= '0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_wbsel_q     <= WB_NONE;
      wb_alu_q       <= '0;
      wb_rd_data_q   <= '0;
      wb_pc4_q       <= '0;
      wb_exc_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      lat_rd_q       <= lat_rd_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_wbsel_q    <= lat_wbsel_d;
      lat_pc4_q      <= lat_pc4_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_wbsel_q     <= wb_wbsel_d;
      wb_alu_q       <= wb_alu_d;
      wb_rd_data_q   <= wb_rd_data_d;
      wb_pc4_q       <= wb_pc4_d;
      wb_exc_q       <= wb_exc_d;
    end
  end

  assign MEM_stall_o     = stall;
  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_be_o       = be_q;
  assign dmem_wdata_o    = wdata_q;
  assign WB_valid_o      = wb_valid_q;
  assign WB_RegWrite_o   = wb_regwrite_q;
  assign WB_rd_addr_o    = wb_rd_q;
  assign WB_WBSel_o      = wb_wbsel_q;
  assign WB_alu_result_o = wb_alu_q;
  assign WB_rd_data_o    = wb_rd_data_q;
  assign WB_pc_plus4_o   = wb_pc4_q;
  assign WB_exc_o        = wb_exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table of single instructions plus
// hand-written sequences for reset mid-transaction and back-to-back ops.
module tb_memory_stage;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_PC4  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0, mr = 1'b0, mw = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] alu = '0, rs2 = '0, pc4 = '0;
  logic [4:0]  rd = '0;
  logic        rw = 1'b0;
  logic [1:0]  sel = WB_NONE;
  logic        stall;
  logic        req, we;
  logic [31:0] daddr, wdata;
  logic [3:0]  be;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_valid, wb_rw, wb_exc;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu, wb_rdd, wb_pc4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_valid_i(valid), .MEM_MemRead_i(mr), .MEM_MemWrite_i(mw),
    .MEM_funct3_i(f3), .MEM_alu_result_i(alu), .MEM_rs2_data_i(rs2),
    .MEM_pc_plus4_i(pc4), .MEM_rd_addr_i(rd), .MEM_RegWrite_i(rw),
    .MEM_WBSel_i(sel), .MEM_stall_o(stall),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(daddr), .dmem_be_o(be),
    .dmem_wdata_o(wdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata),
    .WB_valid_o(wb_valid), .WB_RegWrite_o(wb_rw), .WB_rd_addr_o(wb_rd),
    .WB_WBSel_o(wb_sel), .WB_alu_result_o(wb_alu), .WB_rd_data_o(wb_rdd),
    .WB_pc_plus4_o(wb_pc4), .WB_exc_o(wb_exc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid, mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          delay;   // BUSY cycles without ack before the ack cycle
    logic        rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdd;
    logic        e_valid, e_rw, e_exc;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    // valid mr mw f3 addr rs2 rdata delay rw sel rd | req we be addr wdata rdd valid rw exc
    vecs[0]  = '{1, 0, 0, 3'b000, 32'h1234_5678, 0, 0, 0, 1, WB_ALU, 5,
                 0, 0, 4'h0, 0, 0, 0, 1, 1, 0};
    vecs[1]  = '{1, 1, 0, 3'b000, 32'h0000_0103, 0, 32'h80AA_BBCC, 3, 1, WB_MEM, 6,
                 1, 0, 4'hF, 32'h100, 0, 32'hFFFF_FF80, 1, 1, 0};
    vecs[2]  = '{1, 1, 0, 3'b100, 32'h0000_0103, 0, 32'h80AA_BBCC, 0, 1, WB_MEM, 7,
                 1, 0, 4'hF, 32'h100, 0, 32'h0000_0080, 1, 1, 0};
    vecs[3]  = '{1, 0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 0, WB_NONE, 0,
                 1, 1, 4'hC, 32'h200, 32'hABCD_ABCD, 0, 1, 0, 0};
    vecs[4]  = '{1, 1, 0, 3'b010, 32'h0000_0006, 0, 0, 0, 1, WB_MEM, 8,
                 0, 0, 4'h0, 0, 0, 0, 1, 0, 1};
    vecs[5]  = '{1, 1, 0, 3'b001, 32'h0000_0102, 0, 32'h8001_1234, 1, 1, WB_MEM, 9,
                 1, 0, 4'hF, 32'h100, 0, 32'hFFFF_8001, 1, 1, 0};
    vecs[6]  = '{1, 1, 0, 3'b101, 32'h0000_0100, 0, 32'h1234_F00D, 2, 1, WB_MEM, 10,
                 1, 0, 4'hF, 32'h100, 0, 32'h0000_F00D, 1, 1, 0};
    vecs[7]  = '{1, 0, 1, 3'b000, 32'h0000_0101, 32'h1234_56EF, 0, 0, 0, WB_NONE, 0,
                 1, 1, 4'b0010, 32'h100, 32'hEFEF_EFEF, 0, 1, 0, 0};
    vecs[8]  = '{1, 0, 1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 0, 1, 0, WB_NONE, 0,
                 1, 1, 4'hF, 32'h300, 32'hDEAD_BEEF, 0, 1, 0, 0};
    vecs[9]  = '{1, 1, 0, 3'b011, 32'h0000_0000, 0, 0, 0, 1, WB_MEM, 11,
                 0, 0, 4'h0, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{1, 0, 1, 3'b100, 32'h0000_0010, 32'h55, 0, 0, 0, WB_NONE, 0,
                 0, 0, 4'h0, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{1, 1, 0, 3'b010, 32'h0000_0040, 0, 32'hCAFE_F00D, 1, 1, WB_MEM, 12,
                 1, 0, 4'hF, 32'h40, 0, 32'hCAFE_F00D, 1, 1, 0};
    vecs[12] = '{1, 1, 0, 3'b000, 32'h0000_0001, 0, 32'h0000_7F00, 0, 1, WB_MEM, 13,
                 1, 0, 4'hF, 32'h0, 0, 32'h0000_007F, 1, 1, 0};
    vecs[13] = '{0, 0, 0, 3'b000, 32'h0000_0099, 0, 0, 0, 1, WB_PC4, 14,
                 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 3'b000, 32'h0000_0000, 0, 0, 0, 1, WB_PC4, 1,
                 0, 0, 4'h0, 0, 0, 0, 1, 1, 0};
    vecs[15] = '{1, 1, 0, 3'b001, 32'h0000_0101, 0, 0, 0, 1, WB_MEM, 15,
                 0, 0, 4'h0, 0, 0, 0, 1, 0, 1};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;
    // Asynchronous reset: outputs clear without a clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wbsel", wb_sel, WB_NONE);
    chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      valid = vecs[i].valid; mr = vecs[i].mr; mw = vecs[i].mw; f3 = vecs[i].f3;
      alu = vecs[i].addr; rs2 = vecs[i].rs2; rdata = vecs[i].rdata;
      rw = vecs[i].rw; sel = vecs[i].sel; rd = vecs[i].rd;
      pc4 = 32'h1000 + 32'(i * 4);
      ack = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d stall_c0", i), stall, vecs[i].e_req);
      chk($sformatf("v%0d req_c0", i), req, 0);
      stalls = 1;
      if (vecs[i].e_req) begin
        for (int c = 0; c <= vecs[i].delay; c++) begin
          @(posedge clk); #1;
          if (c == vecs[i].delay) ack = 1'b1;
          @(negedge clk);
          if (stall) stalls++;
          chk($sformatf("v%0d req_c%0d", i, c + 1), req, 1);
          if (c == 0) begin
            chk($sformatf("v%0d we", i), we, vecs[i].e_we);
            chk($sformatf("v%0d be", i), be, vecs[i].e_be);
            chk($sformatf("v%0d addr", i), daddr, vecs[i].e_addr);
            if (vecs[i].e_we) chk($sformatf("v%0d wdata", i), wdata, vecs[i].e_wdata);
          end
        end
        chk($sformatf("v%0d stall_cycles", i), stalls, vecs[i].delay + 1);
      end
      @(posedge clk); #1;
      valid = 1'b0; mr = 1'b0; mw = 1'b0; ack = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].e_valid);
      chk($sformatf("v%0d wb_rw", i), wb_rw, vecs[i].e_rw);
      chk($sformatf("v%0d wb_exc", i), wb_exc, vecs[i].e_exc);
      chk($sformatf("v%0d req_after", i), req, 0);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d wb_rdd", i), wb_rdd, vecs[i].e_rdd);
        chk($sformatf("v%0d wb_rd", i), wb_rd, vecs[i].rd);
        chk($sformatf("v%0d wb_alu", i), wb_alu, vecs[i].addr);
        chk($sformatf("v%0d wb_pc4", i), wb_pc4, 32'h1000 + 32'(i * 4));
        chk($sformatf("v%0d wb_sel", i), wb_sel, vecs[i].sel);
      end
    end

    // Reset while a load is outstanding
    @(posedge clk); #1;
    valid = 1'b1; mr = 1'b1; f3 = 3'b010; alu = 32'h10; rd = 5'd3; rw = 1'b1; sel = WB_MEM;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy req_before", req, 1);
    valid = 1'b0; mr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rstbusy req", req, 0);
    chk("rstbusy wb_valid", wb_valid, 0);
    chk("rstbusy wb_pc4", wb_pc4, 0);
    chk("rstbusy wb_alu", wb_alu, 0);
    chk("rstbusy wb_rd", wb_rd, 0);
    chk("rstbusy wb_sel", wb_sel, WB_NONE);
    chk("rstbusy addr", daddr, 0);
    chk("rstbusy be", be, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    ack = 1'b1;  // late ack, must be ignored in IDLE
    rdata = 32'h1111_2222;
    @(negedge clk);
    chk("lateack stall", stall, 0);
    chk("lateack req", req, 0);
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("lateack wb_valid", wb_valid, 0);
    chk("lateack req2", req, 0);

    // Back-to-back SW then LW, each acked in its first BUSY cycle
    @(posedge clk); #1;
    valid = 1'b1; mw = 1'b1; mr = 1'b0; f3 = 3'b010; alu = 32'h20; rs2 = 32'hA5A5_5A5A;
    rw = 1'b0; sel = WB_NONE; rd = 5'd0;
    @(negedge clk);
    chk("b2b sw stall_c0", stall, 1);
    @(posedge clk); #1;
    ack = 1'b1;
    @(negedge clk);
    chk("b2b sw req", req, 1);
    chk("b2b sw wdata", wdata, 32'hA5A5_5A5A);
    chk("b2b sw stall_ack", stall, 0);
    @(posedge clk); #1;
    ack = 1'b0; mw = 1'b0; mr = 1'b1; alu = 32'h24; rd = 5'd9; rw = 1'b1; sel = WB_MEM;
    rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    chk("b2b sw retire", wb_valid, 1);
    chk("b2b lw stall_c0", stall, 1);
    @(posedge clk); #1;
    ack = 1'b1;
    @(negedge clk);
    chk("b2b bubble", wb_valid, 0);
    chk("b2b lw addr", daddr, 32'h24);
    @(posedge clk); #1;
    ack = 1'b0; valid = 1'b0; mr = 1'b0;
    @(negedge clk);
    chk("b2b lw retire", wb_valid, 1);
    chk("b2b lw rdd", wb_rdd, 32'h0BAD_CAFE);
    chk("b2b lw rd", wb_rd, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
